// File: rtl/hazard_scoreboard.sv
// Pipeline hazard scoreboard: tracks EX/MEM/WB destination tags and produces
// per-source forwarding selects plus a one-cycle load-use stall and a stall counter.
module hazard_scoreboard #(
  parameter int REG_AW  = 3,
  parameter int NSRC    = 2,
  parameter int CNT_W   = 16,
  parameter int R0_ZERO = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   id_valid,
  input  logic                   id_flush,
  input  logic [NSRC*REG_AW-1:0] id_src,
  input  logic [NSRC-1:0]        id_src_use,
  input  logic [REG_AW-1:0]      id_dest,
  input  logic                   id_regwr,
  input  logic                   id_memrd,
  input  logic                   freeze,
  output logic [2*NSRC-1:0]      fwd_sel,
  output logic                   stall,
  output logic [CNT_W-1:0]       stall_count
);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] dest;
    logic              regwr;
    logic              memrd;
  } tag_t;

  tag_t             exTag_q, memTag_q, wbTag_q;
  tag_t             exTag_d;
  logic [CNT_W-1:0] stallCount_q, stallCount_d;
  logic             loadUse;

  function automatic logic stageHit(input tag_t t, input logic [REG_AW-1:0] src,
                                    input logic srcUsed);
    return srcUsed && t.valid && t.regwr && (t.dest == src) &&
           ((R0_ZERO == 0) || (src != '0));
  endfunction

  // Youngest producer wins; the load-use test only looks at the EX stage.
  always_comb begin
    fwd_sel = '0;
    loadUse = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (stageHit(exTag_q, id_src[i*REG_AW +: REG_AW], id_src_use[i])) begin
        fwd_sel[2*i +: 2] = 2'b01;
        if (exTag_q.memrd) loadUse = 1'b1;
      end else if (stageHit(memTag_q, id_src[i*REG_AW +: REG_AW], id_src_use[i])) begin
        fwd_sel[2*i +: 2] = 2'b10;
      end else if (stageHit(wbTag_q, id_src[i*REG_AW +: REG_AW], id_src_use[i])) begin
        fwd_sel[2*i +: 2] = 2'b11;
      end
    end
  end

  assign stall = id_valid && !id_flush && loadUse;

  always_comb begin
    exTag_d = '0;
    if (id_valid && !id_flush && !stall) begin
      exTag_d.valid = 1'b1;
      exTag_d.dest  = id_dest;
      exTag_d.regwr = id_regwr;
      exTag_d.memrd = id_memrd;
    end
  end

  assign stallCount_d = (stall && (stallCount_q != '1)) ? stallCount_q + CNT_W'(1)
                                                         : stallCount_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exTag_q      <= '0;
      memTag_q     <= '0;
      wbTag_q      <= '0;
      stallCount_q <= '0;
    end else if (!freeze) begin
      exTag_q      <= exTag_d;
      memTag_q     <= exTag_q;
      wbTag_q      <= memTag_q;
      stallCount_q <= stallCount_d;
    end
  end

  assign stall_count = stallCount_q;

  // Older stages carry memrd only for tag uniformity; nothing downstream reads it.
  logic unusedMemrd;
  assign unusedMemrd = memTag_q.memrd ^ wbTag_q.memrd;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: cycle-by-cycle model compare on the
// default instance plus directed checks, and an R0_ZERO=1 / CNT_W=2 instance.
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       reset;
  logic       idValid, idFlush, idRegwr, idMemrd, freeze;
  logic [5:0] idSrc;
  logic [1:0] idUse;
  logic [2:0] idDest;
  logic [3:0] fwdSel;
  logic       stall;
  logic [15:0] stallCount;

  logic       bValid, bRegwr, bMemrd;
  logic [5:0] bSrc;
  logic [1:0] bUse;
  logic [2:0] bDest;
  logic [3:0] bFwd;
  logic       bStall;
  logic [1:0] bCount;

  int total = 0;
  int bad   = 0;
  bit checkOn = 1'b0;

  hazard_scoreboard dut (
    .clk(clk), .reset(reset), .id_valid(idValid), .id_flush(idFlush),
    .id_src(idSrc), .id_src_use(idUse), .id_dest(idDest), .id_regwr(idRegwr),
    .id_memrd(idMemrd), .freeze(freeze), .fwd_sel(fwdSel), .stall(stall),
    .stall_count(stallCount)
  );

  hazard_scoreboard #(.R0_ZERO(1), .CNT_W(2)) dutB (
    .clk(clk), .reset(reset), .id_valid(bValid), .id_flush(1'b0),
    .id_src(bSrc), .id_src_use(bUse), .id_dest(bDest), .id_regwr(bRegwr),
    .id_memrd(bMemrd), .freeze(1'b0), .fwd_sel(bFwd), .stall(bStall),
    .stall_count(bCount)
  );

  always #5 clk = ~clk;

  // Reference model: index 0 is the youngest in-flight instruction (EX).
  logic       mValid [3];
  logic [2:0] mDest  [3];
  logic       mRegwr [3];
  logic       mMemrd [3];
  int         mCount;

  function automatic logic [1:0] expFwd(input int i);
    logic [2:0] src;
    src = idSrc[i*3 +: 3];
    if (!idUse[i]) return 2'b00;
    for (int s = 0; s < 3; s++)
      if (mValid[s] && mRegwr[s] && mDest[s] == src) return 2'(s + 1);
    return 2'b00;
  endfunction

  function automatic logic expStall();
    if (!idValid || idFlush) return 1'b0;
    for (int i = 0; i < 2; i++)
      if (idUse[i] && mValid[0] && mRegwr[0] && mMemrd[0] && mDest[0] == idSrc[i*3 +: 3])
        return 1'b1;
    return 1'b0;
  endfunction

  always @(posedge clk or posedge reset) begin : modelUpdate
    logic st;
    if (reset) begin
      for (int s = 0; s < 3; s++) begin
        mValid[s] = 1'b0; mDest[s] = '0; mRegwr[s] = 1'b0; mMemrd[s] = 1'b0;
      end
      mCount = 0;
    end else if (!freeze) begin
      st = expStall();
      for (int s = 2; s > 0; s--) begin
        mValid[s] = mValid[s-1]; mDest[s] = mDest[s-1];
        mRegwr[s] = mRegwr[s-1]; mMemrd[s] = mMemrd[s-1];
      end
      mValid[0] = idValid && !idFlush && !st;
      mDest[0]  = idDest;
      mRegwr[0] = idRegwr;
      mMemrd[0] = idMemrd;
      if (st && mCount < 65535) mCount = mCount + 1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Every falling edge the default instance must agree with the model.
  always @(negedge clk) begin
    if (checkOn) begin
      checkOutput("model_fwd", 32'(fwdSel), 32'({expFwd(1), expFwd(0)}));
      checkOutput("model_stall", 32'(stall), 32'(expStall()));
      checkOutput("model_count", 32'(stallCount), 32'(16'(mCount)));
    end
  end

  task automatic applyStimulus(input logic v, f, input logic [2:0] s0, s1,
                               input logic [1:0] u, input logic [2:0] d,
                               input logic w, m, fr);
    idValid = v; idFlush = f; idSrc = {s1, s0}; idUse = u;
    idDest = d; idRegwr = w; idMemrd = m; freeze = fr;
    #1;
  endtask

  task automatic applyB(input logic v, input logic [2:0] s0, input logic [1:0] u,
                        input logic [2:0] d, input logic w, m);
    bValid = v; bSrc = {3'd0, s0}; bUse = u; bDest = d; bRegwr = w; bMemrd = m;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyB(0, 0, 0, 0, 0, 0);
    checkOn = 1'b1;
    step(); step();
    checkOutput("reset_stall", 32'(stall), 32'd0);
    checkOutput("reset_fwd", 32'(fwdSel), 32'd0);
    checkOutput("reset_count", 32'(stallCount), 32'd0);
    reset = 1'b0;

    // ALU producer r1 followed by a reader of r1 on source 0.
    applyStimulus(1, 0, 0, 0, 2'b00, 1, 1, 0, 0); step();
    applyStimulus(1, 0, 1, 0, 2'b01, 5, 0, 0, 0);
    checkOutput("alu_ex", 32'(fwdSel[1:0]), 32'b01);
    checkOutput("alu_nostall", 32'(stall), 32'd0);
    step();
    checkOutput("alu_mem", 32'(fwdSel[1:0]), 32'b10);
    step();
    checkOutput("alu_wb", 32'(fwdSel[1:0]), 32'b11);
    step();
    checkOutput("alu_rf", 32'(fwdSel[1:0]), 32'b00);
    idle(3);

    // Load r2, then a reader of r2 on source 1.
    applyStimulus(1, 0, 0, 0, 2'b00, 2, 1, 1, 0); step();
    applyStimulus(1, 0, 0, 2, 2'b10, 6, 1, 0, 0);
    checkOutput("lu_stall", 32'(stall), 32'd1);
    checkOutput("lu_count0", 32'(stallCount), 32'd0);
    step();
    checkOutput("lu_after_stall", 32'(stall), 32'd0);
    checkOutput("lu_after_fwd", 32'(fwdSel[3:2]), 32'b10);
    checkOutput("lu_count1", 32'(stallCount), 32'd1);
    step();
    idle(3);

    // Flush beats a load-use condition.
    applyStimulus(1, 0, 0, 0, 2'b00, 3, 1, 1, 0); step();
    applyStimulus(1, 1, 3, 0, 2'b01, 6, 1, 0, 0);
    checkOutput("flush_nostall", 32'(stall), 32'd0);
    checkOutput("flush_fwd_indep", 32'(fwdSel[1:0]), 32'b01);
    step();
    applyStimulus(1, 0, 3, 0, 2'b01, 6, 0, 0, 0);
    checkOutput("flush_bubble_fwd", 32'(fwdSel[1:0]), 32'b10);
    checkOutput("flush_count", 32'(stallCount), 32'd1);
    idle(3);

    // Stall held under freeze, then released.
    applyStimulus(1, 0, 0, 0, 2'b00, 5, 1, 1, 0); step();
    applyStimulus(1, 0, 5, 0, 2'b01, 6, 1, 0, 1);
    for (int k = 0; k < 3; k++) begin
      step();
      checkOutput("frz_stall", 32'(stall), 32'd1);
      checkOutput("frz_count", 32'(stallCount), 32'd1);
    end
    applyStimulus(1, 0, 5, 0, 2'b01, 6, 1, 0, 0);
    step();
    checkOutput("frz_release_count", 32'(stallCount), 32'd2);
    checkOutput("frz_release_fwd", 32'(fwdSel[1:0]), 32'b10);
    idle(4);

    // Two in-flight writers of r4: the younger one is selected.
    applyStimulus(1, 0, 0, 0, 2'b00, 4, 1, 0, 0); step();
    applyStimulus(1, 0, 0, 0, 2'b00, 4, 1, 0, 0); step();
    applyStimulus(1, 0, 0, 4, 2'b10, 7, 0, 0, 0);
    checkOutput("prio_ex", 32'(fwdSel[3:2]), 32'b01);
    idle(3);

    // A non-writing instruction never forwards.
    applyStimulus(1, 0, 0, 0, 2'b00, 6, 0, 0, 0); step();
    applyStimulus(1, 0, 6, 0, 2'b01, 1, 0, 0, 0);
    checkOutput("noregwr_fwd", 32'(fwdSel[1:0]), 32'b00);
    idle(3);

    // Reset arriving mid-stall clears everything at once.
    applyStimulus(1, 0, 0, 0, 2'b00, 2, 1, 1, 0); step();
    applyStimulus(1, 0, 0, 2, 2'b10, 6, 1, 0, 0);
    checkOutput("pre_reset_stall", 32'(stall), 32'd1);
    #2 reset = 1'b1;
    #1;
    checkOutput("async_reset_stall", 32'(stall), 32'd0);
    checkOutput("async_reset_count", 32'(stallCount), 32'd0);
    checkOutput("async_reset_fwd", 32'(fwdSel), 32'd0);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    applyStimulus(1, 0, 0, 0, 2'b00, 7, 1, 0, 0); step();
    applyStimulus(1, 0, 7, 0, 2'b01, 1, 0, 0, 0);
    checkOutput("post_reset_fwd", 32'(fwdSel[1:0]), 32'b01);
    idle(3);

    // Second instance: r0 is never a hazard source.
    applyB(1, 0, 2'b00, 0, 1, 1); step();
    applyB(1, 0, 2'b01, 3, 1, 0);
    checkOutput("r0_fwd", 32'(bFwd), 32'd0);
    checkOutput("r0_stall", 32'(bStall), 32'd0);
    step();
    applyB(0, 0, 0, 0, 0, 0);
    step(); step(); step();

    // "ld r1,(r1)" held in decode stalls every other cycle; the 2-bit counter saturates.
    applyB(1, 1, 2'b01, 1, 1, 1);
    for (int k = 1; k <= 10; k++) begin
      step();
      if (k == 4) checkOutput("sat_count2", 32'(bCount), 32'd2);
      if (k == 6) checkOutput("sat_count3", 32'(bCount), 32'd3);
      if (k == 9) checkOutput("sat_stall", 32'(bStall), 32'd1);
    end
    checkOutput("sat_hold", 32'(bCount), 32'd3);
    applyB(0, 0, 0, 0, 0, 0);
    step();

    checkOn = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
